// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: bundles the two master ports, the shared slave port
// and the grant index of the peripheral bus arbiter.
// The slave modport is the arbiter's own view (it serves the masters and
// drives the slave bus); the master modport is the view of the surrounding
// system (the masters making requests and the peripheral answering them).
interface periph_bus_arbiter_if;
  // master 0: CPU MEM-stage data port
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_ack_o;
  logic        m0_err_o;
  logic [31:0] m0_rdata_o;

  // master 1: debug/loader port
  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_ack_o;
  logic        m1_err_o;
  logic [31:0] m1_rdata_o;

  // shared peripheral bus
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;

  // index of the current or most recent grant
  logic        owner_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_ack_o, m0_err_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_ack_o, m1_err_o, m1_rdata_o,
    output s_stb_o, s_we_o, s_addr_o, s_wdata_o,
    input  s_rdata_i, s_ack_i,
    output owner_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_ack_o, m0_err_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_ack_o, m1_err_o, m1_rdata_o,
    input  s_stb_o, s_we_o, s_addr_o, s_wdata_o,
    output s_rdata_i, s_ack_i,
    input  owner_o
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter for the memory-mapped
// peripheral bus. One transaction at a time on a strobe/ack handshake; the
// winning master gets a one-cycle ack together with its read data.
//
// Optional watchdog: define ARB_TIMEOUT_EN to abort transactions whose slave
// has not acked within TIMEOUT_CYCLES strobe cycles (err=1, rdata=DEAD_BEEF).
// Without it, BUSY waits forever and the err outputs are tied low.
//
// state | meaning
// IDLE  | no transaction; arbitrate among pending requests
// BUSY  | s_stb_o high, waiting for s_ack_i (or the watchdog)
// RESP  | ack pulse to the owner; masters may drop or renew requests
module periph_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  periph_bus_arbiter_if.slave bus
);

  localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

  // watchdog limit must fit the 8-bit counter and allow at least one wait
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("periph_bus_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        s_stb_q, s_stb_d;
  logic        s_we_q, s_we_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic        owner_q, owner_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        req_any;
  logic        winner;
  logic        abort;

  // Arbitration: a lone requester wins; on a tie the master that is not the
  // most recent owner wins, which yields strict alternation under load.
  always_comb begin
    req_any = bus.m0_req_i | bus.m1_req_i;
    winner  = (bus.m0_req_i & bus.m1_req_i) ? ~owner_q : bus.m1_req_i;
  end

`ifdef ARB_TIMEOUT_EN
  // cnt_q counts BUSY cycles without ack, so on strobe cycle k it holds k-1
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       m0_err_q, m0_err_d;
  logic       m1_err_q, m1_err_d;

  // Abort only if the last allowed strobe cycle passes without an ack; an ack
  // arriving in that same cycle still completes the transaction normally.
  assign abort = (state_q == ST_BUSY) && !bus.s_ack_i && (cnt_q == TC_LAST);

  // Watchdog counter next state and err flags that accompany the ack pulse.
  always_comb begin
    cnt_d    = cnt_q;
    m0_err_d = abort & ~owner_q;
    m1_err_d = abort & owner_q;
    if (state_q == ST_IDLE && req_any) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_BUSY && !bus.s_ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= 8'd0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      m0_err_q <= m0_err_d;
      m1_err_q <= m1_err_d;
    end
  end

  assign bus.m0_err_o = m0_err_q;
  assign bus.m1_err_o = m1_err_q;
`else
  assign abort        = 1'b0;
  assign bus.m0_err_o = 1'b0;
  assign bus.m1_err_o = 1'b0;
`endif

  // FSM next state and bus/response datapath.
  always_comb begin
    state_d    = state_q;
    s_stb_d    = s_stb_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    owner_d    = owner_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          owner_d   = winner;
          s_stb_d   = 1'b1;
          s_we_d    = winner ? bus.m1_we_i    : bus.m0_we_i;
          s_addr_d  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
          s_wdata_d = winner ? bus.m1_wdata_i : bus.m0_wdata_i;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (bus.s_ack_i || abort) begin
          s_stb_d = 1'b0;
          s_we_d  = 1'b0;
          state_d = ST_RESP;
          if (owner_q) begin
            m1_ack_d = 1'b1;
          end else begin
            m0_ack_d = 1'b1;
          end
          // writes leave the owner's read data untouched unless aborted
          if (abort) begin
            if (owner_q) m1_rdata_d = ABORT_RDATA;
            else         m0_rdata_d = ABORT_RDATA;
          end else if (!s_we_q) begin
            if (owner_q) m1_rdata_d = bus.s_rdata_i;
            else         m0_rdata_d = bus.s_rdata_i;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      s_stb_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= 32'd0;
      s_wdata_q  <= 32'd0;
      owner_q    <= 1'b1;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      s_stb_q    <= s_stb_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      owner_q    <= owner_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus.s_stb_o    = s_stb_q;
  assign bus.s_we_o     = s_we_q;
  assign bus.s_addr_o   = s_addr_q;
  assign bus.s_wdata_o  = s_wdata_q;
  assign bus.owner_o    = owner_q;
  assign bus.m0_ack_o   = m0_ack_q;
  assign bus.m1_ack_o   = m1_ack_q;
  assign bus.m0_rdata_o = m0_rdata_q;
  assign bus.m1_rdata_o = m1_rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: scoreboard bench for periph_bus_arbiter. Expected
// grants and responses are queued when a master request is driven and are
// popped when the arbiter raises s_stb_o or an ack. Build with ARB_TIMEOUT_EN
// defined to exercise the watchdog abort path.
module tb_periph_bus_arbiter;

  localparam int          TO        = 16;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  periph_bus_arbiter_if bus ();

  periph_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        mst;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  grant_t      grant_q[$];
  resp_t       resp_q[$];
  int          rise_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_rdata [2];
  int          ack_cnt   [2];
  int          stb_run, last_stb_len;
  logic        stb_prev, ack_prev;

  // slave model knobs: ack on strobe cycle slv_wait, or never
  int          slv_wait  = 1;
  bit          slv_never = 1'b0;
  logic [31:0] slv_key   = 32'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Peripheral model: read data is the address scrambled by a per-test key.
  initial begin
    int age;
    age = 0;
    bus.s_ack_i   = 1'b0;
    bus.s_rdata_i = 32'hBAD0_0000;
    forever begin
      @(posedge clk_i);
      #1;
      if (bus.s_stb_o) age++;
      else             age = 0;
      bus.s_ack_i   = bus.s_stb_o && !slv_never && (age == slv_wait);
      bus.s_rdata_i = bus.s_ack_i ? (slv_key ^ bus.s_addr_o) : 32'hBAD0_0000;
    end
  end

  // Monitor: pops the scoreboard on strobe rise and on every ack pulse.
  initial begin
    grant_t g;
    resp_t  r;
    logic   m;
    stb_prev = 1'b0; ack_prev = 1'b0; stb_run = 0; last_stb_len = 0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        stb_prev = 1'b0; ack_prev = 1'b0; stb_run = 0;
      end else begin
        if (bus.s_stb_o && !stb_prev) begin
          chk("grant_pending", 32'(grant_q.size() > 0), 32'd1);
          if (grant_q.size() > 0) begin
            g = grant_q.pop_front();
            chk("grant_owner", 32'(bus.owner_o), 32'(g.mst));
            chk("grant_we", 32'(bus.s_we_o), 32'(g.we));
            chk("grant_addr", bus.s_addr_o, g.addr);
            if (g.we) chk("grant_wdata", bus.s_wdata_o, g.wdata);
          end
          rise_cyc.push_back(cyc);
        end
        if (bus.s_stb_o) stb_run++;
        else if (stb_prev) begin
          last_stb_len = stb_run;
          stb_run = 0;
        end
        if (bus.m0_ack_o || bus.m1_ack_o) begin
          chk("ack_onehot", 32'(bus.m0_ack_o & bus.m1_ack_o), 32'd0);
          chk("ack_pulse", 32'(ack_prev), 32'd0);
          m = bus.m1_ack_o;
          ack_cnt[m]++;
          chk("resp_pending", 32'(resp_q.size() > 0), 32'd1);
          if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            chk("ack_master", 32'(m), 32'(r.mst));
            chk("ack_rdata", m ? bus.m1_rdata_o : bus.m0_rdata_o, r.rdata);
            chk("ack_err", 32'(m ? bus.m1_err_o : bus.m0_err_o), 32'(r.err));
          end
        end
        stb_prev = bus.s_stb_o;
        ack_prev = bus.m0_ack_o | bus.m1_ack_o;
      end
    end
  end

  // kind: 0 normal completion, 1 watchdog abort, 2 no response at all
  task automatic expect_txn(input bit m, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input int kind);
    grant_t g;
    resp_t  r;
    g = '{mst: m, we: we, addr: addr, wdata: wd};
    grant_q.push_back(g);
    if (kind == 1)      exp_rdata[m] = DEAD_BEEF;
    else if (!we)       exp_rdata[m] = slv_key ^ addr;
    if (kind != 2) begin
      r = '{mst: m, rdata: exp_rdata[m], err: (kind == 1)};
      resp_q.push_back(r);
    end
  endtask

  task automatic drive_req(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    if (m) begin
      bus.m1_req_i = 1'b1; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
    end else begin
      bus.m0_req_i = 1'b1; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
    end
  endtask

  task automatic req_off(input bit m);
    if (m) bus.m1_req_i = 1'b0;
    else   bus.m0_req_i = 1'b0;
  endtask

  task automatic req_on(input bit m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input int kind);
    drive_req(m, we, addr, wd);
    expect_txn(m, we, addr, wd, kind);
  endtask

  // waits for the master's ack within budget cycles, then drops its request
  task automatic wait_ack(input string tag, input bit m, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (m ? bus.m1_ack_o : bus.m0_ack_o) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
    req_off(m);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"},      32'(bus.s_stb_o),  32'd0);
    chk({tag, "_we"},       32'(bus.s_we_o),   32'd0);
    chk({tag, "_addr"},     bus.s_addr_o,      32'd0);
    chk({tag, "_wdata"},    bus.s_wdata_o,     32'd0);
    chk({tag, "_owner"},    32'(bus.owner_o),  32'd1);
    chk({tag, "_m0_ack"},   32'(bus.m0_ack_o), 32'd0);
    chk({tag, "_m1_ack"},   32'(bus.m1_ack_o), 32'd0);
    chk({tag, "_m0_err"},   32'(bus.m0_err_o), 32'd0);
    chk({tag, "_m1_err"},   32'(bus.m1_err_o), 32'd0);
    chk({tag, "_m0_rdata"}, bus.m0_rdata_o,    32'd0);
    chk({tag, "_m1_rdata"}, bus.m1_rdata_o,    32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    grant_q.delete();
    resp_q.delete();
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n_ack, a0, a1;
    rst_i = 1'b1;
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'd0; bus.m0_wdata_i = 32'd0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'd0; bus.m1_wdata_i = 32'd0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_vals("rst");
    rst_i = 1'b0;

    // single m0 read, zero-wait slave returning 5
    slv_key = 32'h8000_0045;
    slv_wait = 1;
    req_on(1'b0, 1'b0, 32'h8000_0040, 32'd0, 0);
    wait_ack("t1_ack", 1'b0, 20);
    chk("t1_stb_len", 32'(last_stb_len), 32'd1);
    chk("t1_m1_acks", 32'(ack_cnt[1]), 32'd0);
    chk("t1_rdata", bus.m0_rdata_o, 32'd5);

    // both masters requesting continuously: m0,m1,m0,m1 three cycles apart
    do_reset();
    slv_key = 32'hA5A5_0000;
    rise_cyc.delete();
    drive_req(1'b0, 1'b0, 32'h8000_0010, 32'd0);
    drive_req(1'b1, 1'b0, 32'h8000_0020, 32'd0);
    for (int k = 0; k < 2; k++) begin
      expect_txn(1'b0, 1'b0, 32'h8000_0010, 32'd0, 0);
      expect_txn(1'b1, 1'b0, 32'h8000_0020, 32'd0, 0);
    end
    n_ack = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      @(negedge clk_i);
      if (bus.m0_ack_o || bus.m1_ack_o) n_ack++;
    end
    req_off(1'b0);
    req_off(1'b1);
    chk("t2_acks", 32'(n_ack), 32'd4);
    chk("t2_rises", 32'(rise_cyc.size()), 32'd4);
    for (int k = 1; k < rise_cyc.size(); k++)
      chk("t2_spacing", 32'(rise_cyc[k] - rise_cyc[k-1]), 32'd3);
    repeat (3) @(negedge clk_i);
    chk("t2_idle", 32'(bus.s_stb_o), 32'd0);

    // m1 write with a 4-cycle slave; m1 read data must be left alone
    slv_wait = 4;
    req_on(1'b1, 1'b1, 32'h8000_0040, 32'h0000_0100, 0);
    wait_ack("t3_ack", 1'b1, 30);
    chk("t3_stb_len", 32'(last_stb_len), 32'd4);
    chk("t3_m1_rdata", bus.m1_rdata_o, 32'hA5A5_0000 ^ 32'h8000_0020);
    @(negedge clk_i);
    chk("t3_we_low", 32'(bus.s_we_o), 32'd0);
    chk("t3_addr_hold", bus.s_addr_o, 32'h8000_0040);
    chk("t3_wdata_hold", bus.s_wdata_o, 32'h0000_0100);

    // slave acks on the last allowed strobe cycle: normal completion
    slv_wait = TO;
    req_on(1'b0, 1'b0, 32'h8000_0044, 32'd0, 0);
    wait_ack("t4_ack", 1'b0, 40);
    chk("t4_stb_len", 32'(last_stb_len), 32'(TO));

    // slave never responds
    slv_never = 1'b1;
`ifdef ARB_TIMEOUT_EN
    req_on(1'b0, 1'b0, 32'h8000_0048, 32'd0, 1);
    wait_ack("t5_abort_rd", 1'b0, 40);
    chk("t5_stb_len_rd", 32'(last_stb_len), 32'(TO));
    chk("t5_rdata_rd", bus.m0_rdata_o, DEAD_BEEF);
    req_on(1'b1, 1'b1, 32'h8000_004C, 32'h1234_5678, 1);
    wait_ack("t5_abort_wr", 1'b1, 40);
    chk("t5_stb_len_wr", 32'(last_stb_len), 32'(TO));
    chk("t5_rdata_wr", bus.m1_rdata_o, DEAD_BEEF);
`else
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    req_on(1'b0, 1'b0, 32'h8000_0048, 32'd0, 2);
    repeat (120) @(negedge clk_i);
    chk("t5_stb_held", 32'(bus.s_stb_o), 32'd1);
    chk("t5_stb_run", 32'(stb_run >= 100), 32'd1);
    chk("t5_no_ack", 32'(ack_cnt[0] + ack_cnt[1]), 32'(a0 + a1));
    do_reset();
`endif
    slv_never = 1'b0;

    // reset during the second strobe cycle of a transaction
    slv_wait = 5;
    req_on(1'b0, 1'b0, 32'h8000_0060, 32'd0, 0);
    begin
      bit up;
      up = 1'b0;
      for (int i = 0; i < 10 && !up; i++) begin
        @(posedge clk_i);
        #1;
        if (bus.s_stb_o) up = 1'b1;
      end
      chk("t6_stb_seen", 32'(up), 32'd1);
    end
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk_reset_vals("t6_rst");
    a0 = ack_cnt[0];
    do_reset();
    chk("t6_no_ack", 32'(ack_cnt[0]), 32'(a0));
    slv_wait = 1;
    slv_key = 32'h0F0F_0000;
    req_on(1'b1, 1'b0, 32'h8000_0050, 32'd0, 0);
    wait_ack("t6_after_ack", 1'b1, 20);
    chk("t6_owner", 32'(bus.owner_o), 32'd1);
    repeat (3) @(negedge clk_i);
    chk("end_grants_drained", 32'(grant_q.size()), 32'd0);
    chk("end_resps_drained", 32'(resp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
